// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes and values, CSR register map,
// evaluator state encoding and a piece-magnitude helper.
package chess_pkg;

  localparam int unsigned BOARD_SQUARES = 64;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned WORD_BYTES    = WORD_W / 8;
  localparam int unsigned SQ_W          = $clog2(BOARD_SQUARES);
  localparam int unsigned CSR_ADDR_W    = 4;

  typedef logic signed [7:0] piece_t;

  localparam piece_t EMPTY  = 8'sd0;
  localparam piece_t PAWN   = 8'sd1;
  localparam piece_t KNIGHT = 8'sd2;
  localparam piece_t BISHOP = 8'sd3;
  localparam piece_t ROOK   = 8'sd4;
  localparam piece_t QUEEN  = 8'sd5;
  localparam piece_t KING   = 8'sd6;

  localparam logic signed [WORD_W-1:0] VAL_PAWN   = 32'sd100;
  localparam logic signed [WORD_W-1:0] VAL_KNIGHT = 32'sd320;
  localparam logic signed [WORD_W-1:0] VAL_BISHOP = 32'sd330;
  localparam logic signed [WORD_W-1:0] VAL_ROOK   = 32'sd500;
  localparam logic signed [WORD_W-1:0] VAL_QUEEN  = 32'sd900;
  localparam logic signed [WORD_W-1:0] VAL_KING   = 32'sd20000;

  // Write map
  localparam logic [CSR_ADDR_W-1:0] REG_START = 4'd0;
  localparam logic [CSR_ADDR_W-1:0] REG_BASE  = 4'd1;
  localparam logic [CSR_ADDR_W-1:0] REG_COUNT = 4'd2;
  localparam logic [CSR_ADDR_W-1:0] REG_SIDE  = 4'd3;
  // Read map
  localparam logic [CSR_ADDR_W-1:0] REG_BEST_IDX   = 4'd0;
  localparam logic [CSR_ADDR_W-1:0] REG_BEST_SCORE = 4'd1;
  localparam logic [CSR_ADDR_W-1:0] REG_STATUS     = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RD,
    ST_SV,
    ST_ACC,
    ST_CMP,
    ST_DONE
  } state_e;

  // -128 maps to 128, which falls outside the legal 1..6 range.
  function automatic logic [7:0] piece_mag(piece_t p);
    return p[7] ? $unsigned(-p) : $unsigned(p);
  endfunction

endpackage

// File: rtl/board_eval_if.sv
// Avalon-MM style bus bundle, used for both the CSR slave port and the
// SDRAM master port of the evaluator.
interface board_eval_if
  import chess_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) ();

  logic              waitrequest;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic [WORD_W-1:0] readdata;
  logic              readdatavalid;
  logic              write;
  logic [WORD_W-1:0] writedata;

  modport master (
    output address, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/board_eval_piece_value.sv
// Combinational piece-code to signed material value lookup with an
// illegal-code flag; illegal codes contribute zero.
module piece_value
  import chess_pkg::*;
(
  input  piece_t                   code_i,
  output logic signed [WORD_W-1:0] value_c_o,
  output logic                     illegal_c_o
);

  logic [7:0]               mag_c;
  logic signed [WORD_W-1:0] mag_val_c;

  always_comb begin
    mag_c       = piece_mag(code_i);
    mag_val_c   = '0;
    illegal_c_o = 1'b0;
    unique case (mag_c)
      $unsigned(EMPTY):  mag_val_c = '0;
      $unsigned(PAWN):   mag_val_c = VAL_PAWN;
      $unsigned(KNIGHT): mag_val_c = VAL_KNIGHT;
      $unsigned(BISHOP): mag_val_c = VAL_BISHOP;
      $unsigned(ROOK):   mag_val_c = VAL_ROOK;
      $unsigned(QUEEN):  mag_val_c = VAL_QUEEN;
      $unsigned(KING):   mag_val_c = VAL_KING;
      default:           illegal_c_o = 1'b1;
    endcase
    value_c_o = code_i[7] ? -mag_val_c : mag_val_c;
  end

endmodule

// File: rtl/board_eval.sv
// Material evaluator: reads N child boards from SDRAM square by square and
// reports the best index/score for the side to move.
// Optional centre pawn/knight bonus is enabled by defining BOARD_EVAL_PST_EN.
module board_eval
  import chess_pkg::*;
#(
  parameter int unsigned MAX_BOARDS   = 32,
  parameter int unsigned BOARD_STRIDE = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  board_eval_if.slave  csr,
  board_eval_if.master mem
);

  localparam int unsigned B_W = (MAX_BOARDS > 1) ? $clog2(MAX_BOARDS) : 1;
  localparam int unsigned N_W = $clog2(MAX_BOARDS + 1);
  localparam logic [SQ_W-1:0] LAST_SQ = SQ_W'(BOARD_SQUARES - 1);

  state_e                   state_q, state_d;
  logic [WORD_W-1:0]        base_q, base_d;
  logic [N_W-1:0]           n_q, n_d;
  logic                     side_q, side_d;
  logic [B_W-1:0]           b_q, b_d;
  logic [SQ_W-1:0]          s_q, s_d;
  logic signed [WORD_W-1:0] acc_q, acc_d;
  piece_t                   piece_q, piece_d;
  logic [WORD_W-1:0]        best_idx_q, best_idx_d;
  logic signed [WORD_W-1:0] best_score_q, best_score_d;
  logic                     best_valid_q, best_valid_d;
  logic                     err_q, err_d;
  logic                     rd_q, rd_d;
  logic [WORD_W-1:0]        addr_q, addr_d;
  logic                     wait_q, wait_d;
  logic [WORD_W-1:0]        rdata_q, rdata_d;
  logic                     rvalid_q, rvalid_d;

  logic                     wr_c, rd_c, better_c, illegal_c;
  logic signed [WORD_W-1:0] val_c, sq_val_c;
  logic [CSR_ADDR_W-1:0]    csr_addr_c;
  logic [WORD_W-9:0]        unused_rdata;

  assign csr_addr_c   = csr.address[CSR_ADDR_W-1:0];
  assign unused_rdata = mem.readdata[WORD_W-1:8];
  // Config and start are only taken in IDLE; DONE ignores writes until acked.
  assign wr_c         = csr.write && (state_q == ST_IDLE);
  assign rd_c         = csr.read && !wait_q;
  assign better_c     = side_q ? (acc_q < best_score_q) : (acc_q > best_score_q);

  piece_value u_piece_value (
    .code_i      (piece_q),
    .value_c_o   (val_c),
    .illegal_c_o (illegal_c)
  );

`ifdef BOARD_EVAL_PST_EN
  logic signed [WORD_W-1:0] bonus_c;
  logic                     centre_c, minor_c;

  // Centre bonus for pawns and knights on d4/e4/d5/e5.
  always_comb begin
    centre_c = (s_q == SQ_W'(27)) || (s_q == SQ_W'(28)) ||
               (s_q == SQ_W'(35)) || (s_q == SQ_W'(36));
    minor_c  = (piece_mag(piece_q) == $unsigned(PAWN)) ||
               (piece_mag(piece_q) == $unsigned(KNIGHT));
    bonus_c  = '0;
    if (centre_c && minor_c) begin
      bonus_c = piece_q[7] ? -32'sd10 : 32'sd10;
    end
  end

  assign sq_val_c = val_c + bonus_c;
`else
  assign sq_val_c = val_c;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (wr_c && (csr_addr_c == REG_START)) state_d = ST_INIT;
      ST_INIT: state_d = (n_q == '0) ? ST_DONE : ST_RD;
      ST_RD:   if (!mem.waitrequest) state_d = ST_SV;
      ST_SV:   if (mem.readdatavalid) state_d = ST_ACC;
      ST_ACC:  state_d = (s_q == LAST_SQ) ? ST_CMP : ST_RD;
      ST_CMP:  state_d = (N_W'(b_q) == (n_q - N_W'(1))) ? ST_DONE : ST_RD;
      ST_DONE: if (rd_c && (csr_addr_c == REG_BEST_IDX)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    base_d       = base_q;
    n_d          = n_q;
    side_d       = side_q;
    b_d          = b_q;
    s_d          = s_q;
    acc_d        = acc_q;
    piece_d      = piece_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    best_valid_d = best_valid_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    rvalid_d     = rd_c;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_c) begin
          unique case (csr_addr_c)
            REG_START: err_d  = 1'b0;
            REG_BASE:  base_d = csr.writedata;
            REG_COUNT: n_d    = (csr.writedata > WORD_W'(MAX_BOARDS)) ?
                                N_W'(MAX_BOARDS) : N_W'(csr.writedata);
            REG_SIDE:  side_d = csr.writedata[0];
            default:   ;
          endcase
        end
      end
      ST_INIT: begin
        b_d          = '0;
        s_d          = '0;
        acc_d        = '0;
        best_valid_d = 1'b0;
        best_idx_d   = '1;
        best_score_d = '0;
      end
      ST_SV: begin
        if (mem.readdatavalid) piece_d = mem.readdata[7:0];
      end
      ST_ACC: begin
        acc_d = acc_q + sq_val_c;
        if (illegal_c) err_d = 1'b1;
        if (s_q != LAST_SQ) s_d = s_q + SQ_W'(1);
      end
      ST_CMP: begin
        // Strict comparison so ties keep the earlier board.
        if (!best_valid_q || better_c) begin
          best_idx_d   = WORD_W'(b_q);
          best_score_d = acc_q;
        end
        best_valid_d = 1'b1;
        b_d          = b_q + B_W'(1);
        s_d          = '0;
        acc_d        = '0;
      end
      default: ;
    endcase

    if (rd_c) begin
      unique case (csr_addr_c)
        REG_BEST_IDX:   rdata_d = best_idx_q;
        REG_BEST_SCORE: rdata_d = best_score_q;
        REG_STATUS:     rdata_d = {30'b0, err_q, state_q == ST_DONE};
        default:        rdata_d = '0;
      endcase
    end

    rd_d   = (state_d == ST_RD);
    wait_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    addr_d = base_q + WORD_W'(b_d) * WORD_W'(BOARD_STRIDE) +
             WORD_W'(s_d) * WORD_W'(WORD_BYTES);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q       <= '0;
      n_q          <= '0;
      side_q       <= 1'b0;
      b_q          <= '0;
      s_q          <= '0;
      acc_q        <= '0;
      piece_q      <= '0;
      best_idx_q   <= '1;
      best_score_q <= '0;
      best_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      wait_q       <= 1'b0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      base_q       <= base_d;
      n_q          <= n_d;
      side_q       <= side_d;
      b_q          <= b_d;
      s_q          <= s_d;
      acc_q        <= acc_d;
      piece_q      <= piece_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      best_valid_q <= best_valid_d;
      err_q        <= err_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      wait_q       <= wait_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign csr.waitrequest   = wait_q;
  assign csr.readdata      = rdata_q;
  assign csr.readdatavalid = rvalid_q;
  assign mem.read          = rd_q;
  assign mem.address       = addr_q;
  assign mem.write         = 1'b0;
  assign mem.writedata     = 32'hFFFF_FFFF;

endmodule
